// File: rtl/audio_sample_scheduler.sv
// audio_sample_scheduler: divides clk_pcm down to a sample tick. On each
// accepted tick it fetches one stereo sample from each of two sources, mixes
// them with per-channel saturation and writes the result to the output FIFO.
// Optional feature macro: AUDIO_SCHED_UNDERRUN_CNT_EN enables the source
// underrun counter. Without it, underrun_cnt is tied to zero.
module audio_sample_scheduler #(
  parameter int unsigned SAMPLE_DIV = 1134
) (
  input  logic        clk_pcm,
  input  logic        aclr,
  input  logic        enable,
  input  logic [15:0] src0_data,
  input  logic [15:0] src1_data,
  input  logic        src0_valid,
  input  logic        src1_valid,
  output logic        src0_ready,
  output logic        src1_ready,
  output logic [15:0] stereo_pcm,
  output logic        stereo_pcm_rdy,
  input  logic        fifo_full,
  output logic        overrun,
  output logic [15:0] underrun_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, MIX = 2'd2, PUSH = 2'd3} state_t;

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

  state_t      state, state_nxt;
  logic [15:0] count_p0;
  logic        tick_p0;
  logic [15:0] hold0_p1, hold1_p1;
  logic [15:0] mix_p2;
  logic        overrun_q;

  // Unsigned 8-bit add that clips at full scale instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  assign tick_p0 = enable && (count_p0 == DIV_LAST);

  // Sample-rate divider; parked at zero while disabled.
  always_ff @(posedge clk_pcm or posedge aclr) begin
    if (aclr)
      count_p0 <= '0;
    else if (!enable || tick_p0)
      count_p0 <= '0;
    else
      count_p0 <= count_p0 + 16'd1;
  end

  // Sequencer state register.
  always_ff @(posedge clk_pcm or posedge aclr) begin
    if (aclr)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state and handshake outputs; PUSH stalls while the FIFO is full.
  always_comb begin
    state_nxt      = state;
    src0_ready     = 1'b0;
    src1_ready     = 1'b0;
    stereo_pcm_rdy = 1'b0;
    case (state)
      IDLE:  if (tick_p0) state_nxt = FETCH;
      FETCH: begin
        src0_ready = src0_valid;
        src1_ready = src1_valid;
        state_nxt  = MIX;
      end
      MIX:   state_nxt = PUSH;
      PUSH:  if (!fifo_full) begin
        stereo_pcm_rdy = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch stage: a missing source keeps its previous sample.
  always_ff @(posedge clk_pcm or posedge aclr) begin
    if (aclr) begin
      hold0_p1 <= '0;
      hold1_p1 <= '0;
    end else if (state == FETCH) begin
      if (src0_valid) hold0_p1 <= src0_data;
      if (src1_valid) hold1_p1 <= src1_data;
    end
  end

  // Mix stage: left and right channels summed independently with clipping.
  always_ff @(posedge clk_pcm or posedge aclr) begin
    if (aclr)
      mix_p2 <= '0;
    else if (state == MIX)
      mix_p2 <= {sat_add8(hold0_p1[15:8], hold1_p1[15:8]),
                 sat_add8(hold0_p1[7:0],  hold1_p1[7:0])};
  end

  assign stereo_pcm = mix_p2;

  // Sticky miss flag: any tick seen while a sequence is still in flight.
  always_ff @(posedge clk_pcm or posedge aclr) begin
    if (aclr)
      overrun_q <= 1'b0;
    else if (tick_p0 && state != IDLE)
      overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;

`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
  logic [1:0]  miss_p1;
  logic [16:0] under_sum;
  logic [15:0] under_q;

  assign miss_p1   = (state == FETCH) ? ({1'b0, ~src0_valid} + {1'b0, ~src1_valid}) : 2'd0;
  assign under_sum = {1'b0, under_q} + {15'd0, miss_p1};

  // Underrun counter, saturating at 16-bit full scale.
  always_ff @(posedge clk_pcm or posedge aclr) begin
    if (aclr)
      under_q <= '0;
    else if (miss_p1 != 2'd0)
      under_q <= under_sum[16] ? 16'hFFFF : under_sum[15:0];
  end

  assign underrun_cnt = under_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scoreboard bench for audio_sample_scheduler with SAMPLE_DIV=8: the driver
// keeps an abstract model (sequence age since accepted tick, held samples,
// clipped mix) and queues each expected FIFO write; a monitor pops on rdy.
module tb_audio_sample_scheduler;

  localparam int DIV = 8;

  logic        clk_pcm = 1'b0;
  logic        aclr = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] src0_data = '0, src1_data = '0;
  logic        src0_valid = 1'b0, src1_valid = 1'b0;
  logic        src0_ready, src1_ready;
  logic [15:0] stereo_pcm;
  logic        stereo_pcm_rdy;
  logic        fifo_full = 1'b0;
  logic        overrun;
  logic [15:0] underrun_cnt;

  audio_sample_scheduler #(.SAMPLE_DIV(DIV)) dut (
    .clk_pcm(clk_pcm), .aclr(aclr), .enable(enable),
    .src0_data(src0_data), .src1_data(src1_data),
    .src0_valid(src0_valid), .src1_valid(src1_valid),
    .src0_ready(src0_ready), .src1_ready(src1_ready),
    .stereo_pcm(stereo_pcm), .stereo_pcm_rdy(stereo_pcm_rdy),
    .fifo_full(fifo_full), .overrun(overrun), .underrun_cnt(underrun_cnt)
  );

  always #5 clk_pcm = ~clk_pcm;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  // Reference model: m_age = -1 when no sample is in flight, otherwise the
  // number of cycles since the accepted tick (1 fetch, 2 mix, >=3 write).
  int          m_cnt = 0;
  int          m_age = -1;
  logic [15:0] m_h0 = '0, m_h1 = '0;
  int          m_ml = 0, m_mr = 0;
  bit          m_ovr = 1'b0;
  int          m_und = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clip(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  // Monitor: every FIFO write must match the oldest queued expectation.
  always @(negedge clk_pcm) begin
    exp_t e;
    if (stereo_pcm_rdy === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdy_unexpected: got pulse data %0h expected no pulse (cycle %0d)", stereo_pcm, cyc);
      end else begin
        e = sbq.pop_front();
        pops++;
        chk("rdy_data", {16'd0, stereo_pcm}, {16'd0, e.data});
      end
    end
  end

  task automatic step(input bit en, input bit v0, input bit v1,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input bit ff, input bit rs);
    bit   tick;
    exp_t e;
    int   exp_und;
    @(posedge clk_pcm);
    #1;
    cyc++;
    if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL rdy_missing: got no pulse expected data %0h (cycle %0d)", sbq[0].data, sbq[0].cyc);
      sbq.delete(0);
    end
    aclr = rs; enable = en; src0_valid = v0; src1_valid = v1;
    src0_data = d0; src1_data = d1; fifo_full = ff;

    tick = !rs && en && (m_cnt == DIV - 1);
    if (!rs && m_age >= 3 && !ff) begin
      e.data = {8'(m_ml), 8'(m_mr)};
      e.cyc  = cyc;
      sbq.push_back(e);
    end

    @(negedge clk_pcm);
`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
    exp_und = rs ? 0 : m_und;
`else
    exp_und = 0;
`endif
    chk("src0_ready", {31'd0, src0_ready}, {31'd0, (!rs && m_age == 1 && v0)});
    chk("src1_ready", {31'd0, src1_ready}, {31'd0, (!rs && m_age == 1 && v1)});
    chk("overrun", {31'd0, overrun}, {31'd0, (!rs && m_ovr)});
    chk("underrun_cnt", {16'd0, underrun_cnt}, 32'(exp_und));
    chk("stereo_pcm", {16'd0, stereo_pcm}, rs ? 32'd0 : 32'((m_ml << 8) | m_mr));

    if (rs) begin
      m_cnt = 0; m_age = -1; m_h0 = '0; m_h1 = '0;
      m_ml = 0; m_mr = 0; m_ovr = 1'b0; m_und = 0;
    end else begin
      if (m_age == 1) begin
        if (v0) m_h0 = d0; else m_und++;
        if (v1) m_h1 = d1; else m_und++;
        if (m_und > 65535) m_und = 65535;
      end
      if (m_age == 2) begin
        m_ml = clip(int'(m_h0[15:8]), int'(m_h1[15:8]));
        m_mr = clip(int'(m_h0[7:0]),  int'(m_h1[7:0]));
      end
      if (tick && m_age != -1) m_ovr = 1'b1;
      if (m_age == -1)      m_age = tick ? 1 : -1;
      else if (m_age < 3)   m_age = m_age + 1;
      else if (!ff)         m_age = -1;
      if (!en)        m_cnt = 0;
      else if (tick)  m_cnt = 0;
      else            m_cnt = m_cnt + 1;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) step(1'b1, 1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0, 1'b1);

    // Mid-scale sources, one per channel
    repeat (40) step(1'b1, 1'b1, 1'b1, 16'h7F00, 16'h007F, 1'b0, 1'b0);
    chk("mix_7f7f", {16'd0, stereo_pcm}, 32'h0000_7F7F);

    // Both channels clip at full scale
    repeat (24) step(1'b1, 1'b1, 1'b1, 16'hC80A, 16'h64FA, 1'b0, 1'b0);
    chk("mix_sat", {16'd0, stereo_pcm}, 32'h0000_FFFF);

    // Source 1 missing: previous sample reused
    repeat (24) step(1'b1, 1'b1, 1'b0, 16'h1020, 16'hAAAA, 1'b0, 1'b0);
    chk("mix_hold", {16'd0, stereo_pcm}, 32'h0000_74FF);

    // FIFO full for 20 cycles from the write stage
    for (int n = 0; n < 3 * DIV && m_age != 3; n++)
      step(1'b1, 1'b1, 1'b1, 16'h0102, 16'h0304, 1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b1, 1'b1, 16'h0102, 16'h0304, 1'b1, 1'b0);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    repeat (16) step(1'b1, 1'b1, 1'b1, 16'h0102, 16'h0304, 1'b0, 1'b0);

    // Reset pulse during the mix stage
    for (int n = 0; n < 3 * DIV && m_age != 2; n++)
      step(1'b1, 1'b1, 1'b1, 16'h2211, 16'h4433, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h2211, 16'h4433, 1'b0, 1'b1);
    chk("after_rst_overrun", {31'd0, overrun}, 32'd0);
    repeat (30) step(1'b1, 1'b1, 1'b1, 16'h2211, 16'h4433, 1'b0, 1'b0);

    // Enable dropped during fetch
    for (int n = 0; n < 3 * DIV && m_age != 1; n++)
      step(1'b1, 1'b1, 1'b1, 16'h0A0B, 16'h0C0D, 1'b0, 1'b0);
    repeat (30) step(1'b0, 1'b1, 1'b1, 16'h0A0B, 16'h0C0D, 1'b0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++)
      step($urandom_range(99, 0) < 95, $urandom_range(99, 0) < 85,
           $urandom_range(99, 0) < 85, 16'($urandom), 16'($urandom),
           $urandom_range(99, 0) < 25, $urandom_range(999, 0) < 3);

    step(1'b1, 1'b1, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("queue_drained", 32'(sbq.size()), 32'd0);
    checks++;
    if (pops < 50) begin
      errors++;
      $display("FAIL rdy_count: got %0d writes expected at least 50", pops);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
